// File: rtl/led_pkg.sv
// Shared types and default 100 MHz timing for the WS2812 strand driver.
package led_pkg;

  typedef enum logic [1:0] {
    LATCH,
    WAIT_COLOR,
    SEND
  } state_t;

  localparam int COLOR_BITS = 24;

  localparam int DEFAULT_BIT_CYCLES   = 125;
  localparam int DEFAULT_T0H_CYCLES   = 35;
  localparam int DEFAULT_T1H_CYCLES   = 70;
  localparam int DEFAULT_RESET_CYCLES = 30000;

  // Wire order on the strand is green, red, blue, MSB first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Produces one WS2812 bit waveform per BIT_CYCLES while start is held high;
// bit_done marks the last cycle of each bit so the parent can present the next one.
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 35,
  parameter int T1H_CYCLES = 70
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_value,
  output logic line,
  output logic bit_done
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt;

  assign bit_done = start && (cnt == CW'(BIT_CYCLES - 1));

  // Counter restarts from 0 whenever start drops, so the first high phase
  // always lands one cycle after start rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      line <= 1'b0;
    end else if (!start) begin
      cnt  <= '0;
      line <= 1'b0;
    end else begin
      line <= bit_value ? (cnt < CW'(T1H_CYCLES)) : (cnt < CW'(T0H_CYCLES));
      cnt  <= bit_done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ws2812_strand_driver.sv
// Walks the strand LED by LED: requests a colour, shifts its 24 GRB bits out
// through the bit encoder, and closes every frame with a low latch period.
module ws2812_strand_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 6,
  parameter int BIT_CYCLES        = DEFAULT_BIT_CYCLES,
  parameter int T0H_CYCLES        = DEFAULT_T0H_CYCLES,
  parameter int T1H_CYCLES        = DEFAULT_T1H_CYCLES,
  parameter int RESET_CYCLES      = DEFAULT_RESET_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH:0]   next_led_request,
  output logic                         strand_out,
  output logic                         frame_done,
  output logic                         underrun
);

  localparam int AW  = LED_ADDRESS_WIDTH + 1;
  localparam int LCW = $clog2(RESET_CYCLES);
  localparam int BW  = $clog2(COLOR_BITS);

  // Upstream handshake: next_led_request names the wanted LED and stays stable
  // for a whole LED slot; the colour bytes are taken only on a cycle where
  // color_valid is high at a load point, so color_valid acts as valid and the
  // load point is the implicit ready. No back-pressure is applied upstream.
  state_t                  state;
  logic [LCW-1:0]          latch_cnt;
  logic [AW-1:0]           led_idx;
  logic [COLOR_BITS-1:0]   shift_q;
  logic [BW-1:0]           bit_idx;
  logic                    bit_done;
  grb_t                    color_in;

  assign color_in = {green_in, red_in, blue_in};

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_encoder (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (state == SEND),
    .bit_value (shift_q[COLOR_BITS-1]),
    .line      (strand_out),
    .bit_done  (bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= LATCH;
      latch_cnt        <= '0;
      led_idx          <= '0;
      shift_q          <= '0;
      bit_idx          <= '0;
      next_led_request <= '0;
      frame_done       <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        LATCH: begin
          if (latch_cnt == LCW'(RESET_CYCLES - 1)) begin
            latch_cnt  <= '0;
            frame_done <= 1'b1;
            state      <= WAIT_COLOR;
          end else begin
            latch_cnt <= latch_cnt + LCW'(1);
          end
        end
        WAIT_COLOR: begin
          if (color_valid) begin
            shift_q          <= color_in;
            led_idx          <= '0;
            bit_idx          <= '0;
            next_led_request <= (NUM_LEDS == 1) ? AW'(NUM_LEDS) : AW'(1);
            state            <= SEND;
          end
        end
        SEND: begin
          if (bit_done) begin
            if (bit_idx == BW'(COLOR_BITS - 1)) begin
              bit_idx <= '0;
              // Back-to-back LEDs: the next colour loads on the same edge the
              // 24th bit ends, so the encoder never sees a gap.
              if (led_idx == AW'(NUM_LEDS - 1)) begin
                state            <= LATCH;
                next_led_request <= '0;
              end else if (color_valid) begin
                shift_q          <= color_in;
                led_idx          <= led_idx + AW'(1);
                next_led_request <= led_idx + AW'(2);
              end else begin
                underrun         <= 1'b1;
                state            <= LATCH;
                next_led_request <= '0;
              end
            end else begin
              shift_q <= {shift_q[COLOR_BITS-2:0], 1'b0};
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: state <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Event scoreboard bench for ws2812_strand_driver: expected request changes,
// bit pulses, underruns and frame_done pulses are queued with their cycle stamps.
module tb_ws2812_strand_driver;

  localparam int NL    = 3;
  localparam int AW    = 7;
  localparam int BITC  = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int RST_C = 20;

  localparam int T_REQ = 1;
  localparam int T_BIT = 2;
  localparam int T_UR  = 3;
  localparam int T_FD  = 4;

  logic          clk;
  logic          rst_n;
  logic [7:0]    green_in;
  logic [7:0]    red_in;
  logic [7:0]    blue_in;
  logic          color_valid;
  logic [AW-1:0] next_led_request;
  logic          strand_out;
  logic          frame_done;
  logic          underrun;

  logic [23:0]   tbl [0:2];
  logic [31:0]   exp_q[$];

  int checks = 0;
  int errors = 0;
  int cutoff = 0;
  int mon_cyc = 0;

  ws2812_strand_driver #(
    .NUM_LEDS          (NL),
    .LED_ADDRESS_WIDTH (6),
    .BIT_CYCLES        (BITC),
    .T0H_CYCLES        (T0H),
    .T1H_CYCLES        (T1H),
    .RESET_CYCLES      (RST_C)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .green_in         (green_in),
    .red_in           (red_in),
    .blue_in          (blue_in),
    .color_valid      (color_valid),
    .next_led_request (next_led_request),
    .strand_out       (strand_out),
    .frame_done       (frame_done),
    .underrun         (underrun)
  );

  // Upstream colour source: answers the current request from a fixed table.
  assign {green_in, red_in, blue_in} =
    (next_led_request < AW'(NL)) ? tbl[next_led_request[1:0]] : 24'h0;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Driver / expectation tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int t, input int v, input int c);
    logic [31:0] tok;
    tok = {t[3:0], v[11:0], c[15:0]};
    if (c <= cutoff) exp_q.push_back(tok);
  endtask

  task automatic push_led(input int req, input int load_cyc, input logic [23:0] color);
    int h;
    push_ev(T_REQ, req, load_cyc);
    for (int i = 0; i < 24; i++) begin
      h = color[23-i] ? T1H : T0H;
      push_ev(T_BIT, h, load_cyc + 1 + BITC * i + h);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_strand_out", {31'b0, strand_out}, 32'd0);
    chk("rst_request", {25'b0, next_led_request}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (mon_cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not seen, next type=%0d val=%0d cyc=%0d",
               name, exp_q.size(), exp_q[0][31:28], exp_q[0][27:16], exp_q[0][15:0]);
      exp_q.delete();
    end
  endtask

  // Scoreboard / monitor
  task automatic observe(input int t, input int v, input int c);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {t[3:0], v[11:0], c[15:0]};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected type=%0d val=%0d cyc=%0d, expected none", t, v, c);
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        errors++;
        $display("FAIL event: got type=%0d val=%0d cyc=%0d expected type=%0d val=%0d cyc=%0d",
                 t, v, c, exp[31:28], exp[27:16], exp[15:0]);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] prev_req;
    logic          prev_strand;
    int            hi_len;
    prev_req    = '0;
    prev_strand = 1'b0;
    hi_len      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_cyc     = 0;
        prev_req    = '0;
        prev_strand = 1'b0;
        hi_len      = 0;
      end else begin
        mon_cyc++;
        if (next_led_request !== prev_req) observe(T_REQ, int'(next_led_request), mon_cyc);
        if (strand_out) begin
          hi_len = prev_strand ? hi_len + 1 : 1;
        end else if (prev_strand) begin
          observe(T_BIT, hi_len, mon_cyc);
        end
        if (underrun) observe(T_UR, 0, mon_cyc);
        if (frame_done) observe(T_FD, 0, mon_cyc);
        prev_req    = next_led_request;
        prev_strand = strand_out;
      end
    end
  end

  // Stimulus
  initial begin
    rst_n       = 1'b0;
    color_valid = 1'b0;
    tbl[0] = 24'h00FF00;
    tbl[1] = 24'hA53C81;
    tbl[2] = 24'h0FF055;

    // Full frame with colours always available, into the start of the next.
    cutoff = 765;
    push_ev(T_FD, 0, 20);
    push_led(1, 21, tbl[0]);
    push_led(2, 261, tbl[1]);
    push_led(3, 501, tbl[2]);
    push_ev(T_REQ, 0, 741);
    push_ev(T_FD, 0, 761);
    push_led(1, 762, tbl[0]);
    color_valid = 1'b1;
    apply_reset();
    wait_cyc(765);
    check_q_empty("frame_continuous");

    // Underrun after LED1, then a stalled upstream after the latch.
    cutoff = 574;
    push_ev(T_FD, 0, 20);
    push_led(1, 21, tbl[0]);
    push_led(2, 261, tbl[1]);
    push_ev(T_REQ, 0, 501);
    push_ev(T_UR, 0, 501);
    push_ev(T_FD, 0, 521);
    push_led(1, 572, tbl[0]);
    apply_reset();
    wait_cyc(300);
    color_valid = 1'b0;
    wait_cyc(571);
    color_valid = 1'b1;
    wait_cyc(574);
    chk("mid_bit_high", {31'b0, strand_out}, 32'd1);
    check_q_empty("underrun_and_stall");

    // Asynchronous reset in the middle of a high phase.
    cutoff = 300;
    push_ev(T_FD, 0, 20);
    push_led(1, 21, tbl[0]);
    push_led(2, 261, tbl[1]);
    apply_reset();
    wait_cyc(300);
    check_q_empty("after_async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
